// File: rtl/cp0_core.sv
// cp0_core: CP0 register block (BadVAddr, Count, Compare, Status, Cause, EPC)
// with a prescaled Count/Compare timer, parametrised hardware interrupt
// lines, exception-entry / ERET sequencing and masked interrupt-pending.
// MMU registers live outside this block.
module cp0_core #(
   parameter int HW_IRQ_NUM = 6,   // hardware interrupt lines, 1..6
   parameter int COUNT_DIV  = 2,   // clock cycles per Count increment, >= 1
   parameter bit SEL_STRICT = 1'b1 // 1: sel != 0 reads 0 and ignores writes
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  we,
   input  logic                  re,
   input  logic [4:0]            rd,
   input  logic [2:0]            sel,
   input  logic [31:0]           dataIn,
   output logic [31:0]           dataOut,
   input  logic [HW_IRQ_NUM-1:0] hw_irq,
   input  logic                  exc_req,
   input  logic [4:0]            exc_code,
   input  logic [31:0]           exc_epc,
   input  logic                  exc_bd,
   input  logic                  exc_bva_we,
   input  logic [31:0]           exc_bva,
   input  logic                  eret,
   output logic                  irq_pending,
   output logic                  timer_irq,
   output logic [31:0]           cp0_epc,
   output logic [31:0]           cp0_status,
   output logic [31:0]           cp0_cause
);

   // Register numbers decoded by this block; everything else reads as 0.
   typedef enum logic [4:0] {
      REG_BADVADDR = 5'd8,
      REG_COUNT    = 5'd9,
      REG_COMPARE  = 5'd11,
      REG_STATUS   = 5'd12,
      REG_CAUSE    = 5'd13,
      REG_EPC      = 5'd14
   } reg_addr_t;

   // Prescaler is at least one bit wide so COUNT_DIV = 1 still elaborates.
   localparam int             PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);

   // Architectural state
   logic [31:0]           bad_vaddr;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic [31:0]           epc;
   logic [7:0]            im;
   logic                  exl;
   logic                  ie;
   logic                  bd;
   logic                  ti;
   logic [4:0]            exc_code_q;
   logic [HW_IRQ_NUM-1:0] hw_q;
   logic [1:0]            ip_sw;
   logic [PW-1:0]         presc;

   // Derived views
   logic        sel_zero;
   logic        access_ok;
   logic        sw_ok;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic        presc_wrap;
   logic [31:0] count_inc;
   logic [5:0]  ip_hw;
   logic [7:0]  ip;
   logic [31:0] status_word;
   logic [31:0] cause_word;
   logic [31:0] rd_data;

   // Software access qualification. Exception entry and ERET discard any
   // software write issued in the same cycle.
   assign sel_zero   = (sel == 3'd0);
   assign access_ok  = !SEL_STRICT || sel_zero;
   assign sw_ok      = we && access_ok && !exc_req && !eret;
   assign wr_count   = sw_ok && (rd == REG_COUNT);
   assign wr_compare = sw_ok && (rd == REG_COMPARE);
   assign wr_status  = sw_ok && (rd == REG_STATUS);
   assign wr_cause   = sw_ok && (rd == REG_CAUSE);
   assign wr_epc     = sw_ok && (rd == REG_EPC);

   assign presc_wrap = (presc == PRESC_LAST);
   assign count_inc  = count + 32'd1;

   // Spread the registered hardware lines onto a fixed 6-bit field; unused
   // positions stay 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      ip_hw = '0;
      for (int i = 0; i < HW_IRQ_NUM; i++) begin
         ip_hw[i] = hw_q[i];
      end
   end

   // IP7 doubles as the timer interrupt line.
   assign ip          = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
   assign status_word = {16'h0000, im, 6'b000000, exl, ie};
   assign cause_word  = {bd, ti, 14'h0000, ip, 1'b0, exc_code_q, 2'b00};

   // Read mux over the pre-edge register values.
   always_comb begin
      rd_data = '0;
      if (access_ok) begin
         case (rd)
            REG_BADVADDR: rd_data = bad_vaddr;
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_STATUS:   rd_data = status_word;
            REG_CAUSE:    rd_data = cause_word;
            REG_EPC:      rd_data = epc;
            default:      rd_data = '0;
         endcase
      end
   end

   // Registered read port; holds its value while re is low.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, which is also what makes a same-cycle
      // read return the old contents of a register being written.
      if (res) begin
         dataOut <= '0;
      end else if (re) begin
         dataOut <= rd_data;
      end
   end

   // Prescaler, Count, Compare and the timer interrupt flag.
   always_ff @(posedge clk) begin
      if (res) begin
         presc   <= '0;
         count   <= '0;
         compare <= 32'hFFFF_FFFF;
         ti      <= 1'b0;
      end else begin
         // A software Count load restarts the prescaler and suppresses the
         // increment, so it can never raise TI by itself.
         if (wr_count) begin
            count <= dataIn;
            presc <= '0;
         end else if (presc_wrap) begin
            count <= count_inc;
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end

         if (wr_compare) begin
            compare <= dataIn;
         end

         // A Compare write beats a match landing on the same edge.
         if (wr_compare) begin
            ti <= 1'b0;
         end else if (!wr_count && presc_wrap && (count_inc == compare)) begin
            ti <= 1'b1;
         end
      end
   end

   // Hardware interrupt lines are sampled every cycle, regardless of
   // exception or software activity.
   always_ff @(posedge clk) begin
      if (res) begin
         hw_q <= '0;
      end else begin
         hw_q <= hw_irq;
      end
   end

   // Exception entry, ERET and software writes to Status, Cause and EPC.
   always_ff @(posedge clk) begin
      if (res) begin
         bad_vaddr  <= '0;
         epc        <= '0;
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         exc_code_q <= '0;
         ip_sw      <= '0;
      end else if (exc_req) begin
         exc_code_q <= exc_code;
         exl        <= 1'b1;
         // A nested exception (EXL already set) keeps the original EPC/BD
         // so the outer handler can still return.
         if (!exl) begin
            epc <= exc_bd ? (exc_epc - 32'd4) : exc_epc;
            bd  <= exc_bd;
         end
         if (exc_bva_we) begin
            bad_vaddr <= exc_bva;
         end
      end else if (eret) begin
         exl <= 1'b0;
      end else begin
         if (wr_status) begin
            im  <= dataIn[15:8];
            exl <= dataIn[1];
            ie  <= dataIn[0];
         end
         if (wr_cause) begin
            ip_sw <= dataIn[9:8];
         end
         if (wr_epc) begin
            epc <= dataIn;
         end
      end
   end

   // Pending interrupt is purely a function of registered state.
   assign irq_pending = ie & ~exl & (|(ip & im));

   assign timer_irq  = ti;
   assign cp0_epc    = epc;
   assign cp0_status = status_word;
   assign cp0_cause  = cause_word;

endmodule

// File: tb/tb_cp0_core.sv
// Self-checking bench for cp0_core: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the register block.
module tb_cp0_core;

   localparam int HW_IRQ_NUM = 6;
   localparam int COUNT_DIV  = 2;
   localparam bit SEL_STRICT = 1'b1;

   logic                  clk;
   logic                  res;
   logic                  we;
   logic                  re;
   logic [4:0]            rd;
   logic [2:0]            sel;
   logic [31:0]           dataIn;
   logic [31:0]           dataOut;
   logic [HW_IRQ_NUM-1:0] hw_irq;
   logic                  exc_req;
   logic [4:0]            exc_code;
   logic [31:0]           exc_epc;
   logic                  exc_bd;
   logic                  exc_bva_we;
   logic [31:0]           exc_bva;
   logic                  eret;
   logic                  irq_pending;
   logic                  timer_irq;
   logic [31:0]           cp0_epc;
   logic [31:0]           cp0_status;
   logic [31:0]           cp0_cause;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   cp0_core #(
      .HW_IRQ_NUM(HW_IRQ_NUM),
      .COUNT_DIV (COUNT_DIV),
      .SEL_STRICT(SEL_STRICT)
   ) dut (
      .clk        (clk),
      .res        (res),
      .we         (we),
      .re         (re),
      .rd         (rd),
      .sel        (sel),
      .dataIn     (dataIn),
      .dataOut    (dataOut),
      .hw_irq     (hw_irq),
      .exc_req    (exc_req),
      .exc_code   (exc_code),
      .exc_epc    (exc_epc),
      .exc_bd     (exc_bd),
      .exc_bva_we (exc_bva_we),
      .exc_bva    (exc_bva),
      .eret       (eret),
      .irq_pending(irq_pending),
      .timer_irq  (timer_irq),
      .cp0_epc    (cp0_epc),
      .cp0_status (cp0_status),
      .cp0_cause  (cp0_cause)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_badva, m_count, m_compare, m_epc, m_dout;
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [4:0]  m_code;
   logic [5:0]  m_hw;
   logic [1:0]  m_ipsw;
   int unsigned m_cycles;   // cycles since Count was last loaded or reset

   function automatic logic [31:0] m_status_word();
      return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
   endfunction

   function automatic logic [31:0] m_cause_word();
      logic [7:0] ipv;
      ipv = {m_hw, m_ipsw};
      if (m_ti) ipv = ipv | 8'h80;
      return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(ipv) << 8) | (32'(m_code) << 2);
   endfunction

   function automatic logic m_irq();
      logic [31:0] c;
      c = m_cause_word();
      return m_ie && !m_exl && ((c[15:8] & m_im) != 8'h00);
   endfunction

   function automatic logic [31:0] m_reg(input logic [4:0] a, input logic [2:0] s);
      if (SEL_STRICT && s != 3'd0) return 32'h0;
      case (a)
         5'd8:    return m_badva;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status_word();
         5'd13:   return m_cause_word();
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic sw;
      logic tick;
      if (res) begin
         m_badva = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0; m_dout = 0;
         m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_code = 0; m_hw = 0;
         m_ipsw = 0; m_cycles = 0;
         return;
      end
      if (re) m_dout = m_reg(rd, sel);
      sw   = we && !exc_req && !eret && (!SEL_STRICT || sel == 3'd0);
      tick = ((m_cycles + 1) % COUNT_DIV) == 0;
      if (sw && rd == 5'd9) begin
         m_count  = dataIn;
         m_cycles = 0;
      end else begin
         m_cycles++;
         if (tick) begin
            m_count = m_count + 1;
            if (m_count == m_compare) m_ti = 1'b1;
         end
      end
      if (sw && rd == 5'd11) begin
         m_compare = dataIn;
         m_ti      = 1'b0;
      end
      m_hw = 6'(hw_irq);
      if (exc_req) begin
         if (!m_exl) begin
            m_epc = exc_bd ? exc_epc - 4 : exc_epc;
            m_bd  = exc_bd;
         end
         m_code = exc_code;
         m_exl  = 1'b1;
         if (exc_bva_we) m_badva = exc_bva;
      end else if (eret) begin
         m_exl = 1'b0;
      end else if (sw) begin
         case (rd)
            5'd12: begin m_im = dataIn[15:8]; m_exl = dataIn[1]; m_ie = dataIn[0]; end
            5'd13: m_ipsw = dataIn[9:8];
            5'd14: m_epc = dataIn;
            default: ;
         endcase
      end
   endtask

   always @(posedge clk) model_step();

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_dataOut", dataOut, m_dout);
         check("cyc_epc", cp0_epc, m_epc);
         check("cyc_status", cp0_status, m_status_word());
         check("cyc_cause", cp0_cause, m_cause_word());
         check("cyc_irq_pending", 32'(irq_pending), 32'(m_irq()));
         check("cyc_timer_irq", 32'(timer_irq), 32'(m_ti));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear();
      we = 0; re = 0; rd = 0; sel = 0; dataIn = 0;
      exc_req = 0; exc_code = 0; exc_epc = 0; exc_bd = 0;
      exc_bva_we = 0; exc_bva = 0; eret = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      clear(); we = 1; rd = a; dataIn = d;
      @(negedge clk);
      clear();
   endtask

   task automatic rdreg(input logic [4:0] a, input string name, input logic [31:0] exp);
      clear(); re = 1; rd = a;
      @(negedge clk);
      clear();
      check(name, dataOut, exp);
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bdv,
                      input logic bwe, input logic [31:0] bva);
      clear(); exc_req = 1; exc_code = code; exc_epc = pc; exc_bd = bdv;
      exc_bva_we = bwe; exc_bva = bva;
      @(negedge clk);
      clear();
   endtask

   task automatic do_eret();
      clear(); eret = 1;
      @(negedge clk);
      clear();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int budget;
      clear();
      res = 1; hw_irq = '0;
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_status", cp0_status, 32'h0);
      check("rst_cause", cp0_cause, 32'h0);
      check("rst_epc", cp0_epc, 32'h0);
      check("rst_dataOut", dataOut, 32'h0);
      res = 0;

      rdreg(5'd11, "rst_compare", 32'hFFFF_FFFF);
      rdreg(5'd12, "rst_status_rd", 32'h0);
      rdreg(5'd13, "rst_cause_rd", 32'h0);

      // Timer match with COUNT_DIV=2.
      wr(5'd9, 32'd5);
      wr(5'd11, 32'd8);
      repeat (5) @(negedge clk);
      rdreg(5'd9, "count_at_match", 32'd8);
      check("ti_set", 32'(timer_irq), 32'd1);
      check("cause_ti", cp0_cause, 32'h4000_8000);
      wr(5'd11, 32'd20);
      check("ti_clr_by_compare", 32'(timer_irq), 32'd0);

      // Timer interrupt through IM7/IE.
      wr(5'd12, 32'h0000_8001);
      budget = 0;
      while (!timer_irq && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("ti_fire", 32'(timer_irq), 32'd1);
      check("irq_pending_on", 32'(irq_pending), 32'd1);

      exc(5'd0, 32'h8000_1000, 1'b0, 1'b1, 32'hDEAD_BEEF);
      check("exc_epc", cp0_epc, 32'h8000_1000);
      check("exc_status", cp0_status, 32'h0000_8003);
      check("exc_irq_masked", 32'(irq_pending), 32'd0);
      do_eret();
      check("eret_status", cp0_status, 32'h0000_8001);

      // Delay-slot exception then a nested one.
      exc(5'd4, 32'h8000_2004, 1'b1, 1'b0, 32'h0);
      check("bd_epc", cp0_epc, 32'h8000_2000);
      check("bd_cause", cp0_cause, 32'hC000_8010);
      exc(5'd5, 32'h0000_9000, 1'b0, 1'b0, 32'h0);
      check("nested_epc", cp0_epc, 32'h8000_2000);
      check("nested_cause", cp0_cause, 32'hC000_8014);
      do_eret();

      // exc_req beats eret and discards a same-cycle write.
      clear(); exc_req = 1; exc_code = 5'd3; exc_epc = 32'hA000_0000; eret = 1;
      we = 1; rd = 5'd14; dataIn = 32'h1234;
      @(negedge clk);
      clear();
      check("prio_epc", cp0_epc, 32'hA000_0000);
      check("prio_status", cp0_status, 32'h0000_8003);
      check("prio_cause", cp0_cause, 32'h4000_800C);
      do_eret();
      check("prio_eret", cp0_status, 32'h0000_8001);

      // BadVAddr is read-only to software; sel != 0 reads 0.
      wr(5'd8, 32'h0);
      rdreg(5'd8, "badvaddr_ro", 32'hDEAD_BEEF);
      clear(); re = 1; rd = 5'd12; sel = 3'd1;
      @(negedge clk);
      clear();
      check("sel_strict_rd", dataOut, 32'h0);

      // Reset beats a same-cycle write.
      clear(); res = 1; we = 1; rd = 5'd9; dataIn = 32'h1234;
      @(negedge clk);
      res = 0; clear();
      check("rst2_status", cp0_status, 32'h0);
      check("rst2_ti", 32'(timer_irq), 32'd0);

      // Cause write mask and hw_irq latency.
      wr(5'd13, 32'hFFFF_FFFF);
      rdreg(5'd13, "cause_wmask", 32'h0000_0300);
      clear(); hw_irq[0] = 1'b1; re = 1; rd = 5'd13;
      @(negedge clk);
      check("hw_irq_lat1", dataOut, 32'h0000_0300);
      @(negedge clk);
      clear();
      check("hw_irq_lat2", dataOut, 32'h0000_0700);
      hw_irq = '0;

      // Reset mid-count.
      repeat (7) @(negedge clk);
      res = 1;
      @(negedge clk);
      res = 0;
      rdreg(5'd9, "count_after_reset", 32'h0);

      // Randomized traffic checked by the every-cycle compare.
      for (int n = 0; n < 4000; n++) begin
         clear();
         res = ($urandom_range(0, 999) == 0);
         we  = ($urandom_range(0, 3) == 0);
         re  = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 7))
            0: rd = 5'd8;
            1: rd = 5'd9;
            2: rd = 5'd11;
            3: rd = 5'd12;
            4: rd = 5'd13;
            5: rd = 5'd14;
            6: rd = 5'($urandom);
            default: rd = 5'd11;
         endcase
         sel    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         dataIn = $urandom;
         if (rd == 5'd11 && $urandom_range(0, 1) != 0) dataIn = m_count + 32'($urandom_range(1, 30));
         if (rd == 5'd9 && $urandom_range(0, 1) != 0) dataIn = m_compare - 32'($urandom_range(1, 10));
         exc_req    = ($urandom_range(0, 19) == 0);
         eret       = ($urandom_range(0, 15) == 0);
         exc_code   = 5'($urandom);
         exc_epc    = $urandom;
         exc_bd     = $urandom_range(0, 1) != 0;
         exc_bva_we = $urandom_range(0, 1) != 0;
         exc_bva    = $urandom;
         if ($urandom_range(0, 15) == 0) hw_irq = HW_IRQ_NUM'($urandom);
         @(negedge clk);
      end
      clear();
      res = 0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
